// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the serial bit comparator.
package serial_cmp_pkg;

  localparam int unsigned DEFAULT_MAX_LEN = 16;

  typedef enum logic {ACCUM, HOLD} cmp_state_t;

  function automatic int unsigned cnt_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/bit_equal_cell.sv
// Single-bit equality: eq is 1 when both input bits agree.
module bit_equal_cell (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = a ~^ b;

endmodule

// File: rtl/serial_bit_comparator.sv
// Counts matching beats of two serial bitstreams per frame and holds the result on a
// valid/ready port. SERIAL_CMP_FIRST_MISMATCH_EN adds out_first_mm (first mismatch index).
module serial_bit_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
  localparam int unsigned CNT_W  = cnt_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_len,
  output logic             out_equal,
  output logic             out_trunc
`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
  ,
  output logic [CNT_W-1:0] out_first_mm
`endif
);

  cmp_state_t       r_state;
  cmp_state_t       w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_out_count;
  logic [CNT_W-1:0] r_out_len;
  logic             r_out_equal;
  logic             r_out_trunc;
  logic [CNT_W-1:0] w_len_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_close;
  logic             w_eq;

  bit_equal_cell u_eq (
    .a  (in_a),
    .b  (in_b),
    .eq (w_eq)
  );

  // Next-state and accumulator update; a frame closes on in_last or at MAX_LEN beats.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_close     = 1'b0;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ACCUM: begin
        if (in_valid) begin
          w_accept  = 1'b1;
          w_len_nxt = r_len + CNT_W'(1);
          w_cnt_nxt = r_cnt + CNT_W'(w_eq);
          if (in_last || (w_len_nxt == CNT_W'(MAX_LEN))) begin
            w_close     = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_out_count <= '0;
      r_out_len   <= '0;
      r_out_equal <= 1'b0;
      r_out_trunc <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ACCUM);
      r_out_valid <= (w_state_nxt == HOLD);
      if (w_close) begin
        r_out_count <= w_cnt_nxt;
        r_out_len   <= w_len_nxt;
        r_out_equal <= (w_cnt_nxt == w_len_nxt);
        r_out_trunc <= ~in_last;
        r_len       <= '0;
        r_cnt       <= '0;
      end else if (w_accept) begin
        r_len <= w_len_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
  // MAX_LEN in r_first_mm means no mismatch seen yet in the current frame.
  logic [CNT_W-1:0] r_first_mm;
  logic [CNT_W-1:0] r_out_first_mm;
  logic [CNT_W-1:0] w_first_nxt;

  always_comb begin
    w_first_nxt = r_first_mm;
    if (w_accept && !w_eq && (r_first_mm == CNT_W'(MAX_LEN))) begin
      w_first_nxt = r_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_mm     <= CNT_W'(MAX_LEN);
      r_out_first_mm <= '0;
    end else if (w_close) begin
      r_out_first_mm <= w_first_nxt;
      r_first_mm     <= CNT_W'(MAX_LEN);
    end else if (w_accept) begin
      r_first_mm <= w_first_nxt;
    end
  end

  assign out_first_mm = r_out_first_mm;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_len   = r_out_len;
  assign out_equal = r_out_equal;
  assign out_trunc = r_out_trunc;

  a_known_bits : assert property (@(posedge clk) disable iff (rst)
    (in_valid && r_in_ready) |-> !$isunknown({in_a, in_b}));

endmodule

// File: tb/tb_serial_bit_comparator.sv
// Randomized self-checking bench for serial_bit_comparator against a frame-level model.
module tb_serial_bit_comparator;
  import serial_cmp_pkg::*;

  localparam int unsigned MAX_LEN = DEFAULT_MAX_LEN;
  localparam int unsigned CNT_W   = cnt_w(MAX_LEN);

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_a      = 1'b0;
  logic             in_b      = 1'b0;
  logic             in_last   = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_len;
  logic             out_equal;
  logic             out_trunc;
`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
  logic [CNT_W-1:0] out_first_mm;
`endif

  serial_bit_comparator #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_len   (out_len),
    .out_equal (out_equal),
    .out_trunc (out_trunc)
`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
    ,
    .out_first_mm (out_first_mm)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: bits of the open frame and the expected held result.
  bit fa[$];
  bit fb[$];
  int e_count;
  int e_len;
  int e_first;
  int e_equal;
  int e_trunc;
  bit m_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic close_model(input bit last);
    e_len   = fa.size();
    e_count = 0;
    e_first = MAX_LEN;
    for (int i = 0; i < fa.size(); i++) begin
      if (fa[i] == fb[i]) e_count++;
      else if (e_first == int'(MAX_LEN)) e_first = i;
    end
    e_equal = (e_count == e_len) ? 1 : 0;
    e_trunc = last ? 0 : 1;
    fa.delete();
    fb.delete();
    m_hold = 1'b1;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_count"}, 32'(out_count), e_count);
    chk({tag, "_len"},   32'(out_len), e_len);
    chk({tag, "_equal"}, 32'(out_equal), e_equal);
    chk({tag, "_trunc"}, 32'(out_trunc), e_trunc);
`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
    chk({tag, "_first_mm"}, 32'(out_first_mm), e_first);
`endif
  endtask

  // Present one beat after some idle cycles; it is accepted at the next edge.
  task automatic send_beat(input bit a, input bit b, input bit last, input int idle);
    repeat (idle) begin
      in_valid  = 1'b0;
      in_a      = 1'($urandom);
      in_b      = 1'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_last   = last;
    out_ready = 1'($urandom);
    chk("beat_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fa.push_back(a);
    fb.push_back(b);
    if (last || fa.size() == int'(MAX_LEN)) begin
      close_model(last);
      check_held("close");
    end else begin
      chk("open_valid", 32'(out_valid), 32'd0);
    end
  endtask

  // Stall the held result, then accept it; a beat offered during acceptance must be ignored.
  task automatic release_result(input int waits, input bit pre, input bit a, input bit b,
                                input bit last);
    repeat (waits) begin
      in_valid  = 1'($urandom);
      in_a      = 1'($urandom);
      in_b      = 1'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'b0;
      tick();
      check_held("hold");
    end
    in_valid  = pre;
    in_a      = a;
    in_b      = b;
    in_last   = last;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_ready", 32'(in_ready), 32'd1);
    m_hold = 1'b0;
  endtask

  initial begin
    bit [3:0] va;
    bit [3:0] vb;
    bit       ra;
    bit       rb;
    bit       rl;
    bit       pre;

    // Reset held three cycles, then released.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_len",   32'(out_len), 32'd0);
    chk("rst_equal", 32'(out_equal), 32'd0);
    chk("rst_trunc", 32'(out_trunc), 32'd0);
`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
    chk("rst_first_mm", 32'(out_first_mm), 32'd0);
`endif

    // Four-beat frame, MSB first; third beat mismatches.
    va = 4'b1011;
    vb = 4'b1001;
    for (int i = 0; i < 4; i++) send_beat(va[3-i], vb[3-i], i == 3, 0);
    chk("d2_count", 32'(out_count), 32'd3);
    chk("d2_len",   32'(out_len), 32'd4);
    chk("d2_equal", 32'(out_equal), 32'd0);
`ifdef SERIAL_CMP_FIRST_MISMATCH_EN
    chk("d2_first_mm", 32'(out_first_mm), 32'd2);
`endif
    release_result(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sixteen equal beats without in_last force-close the frame; 17th beat opens a new one.
    for (int i = 0; i < 16; i++) begin
      ra = 1'($urandom);
      send_beat(ra, ra, 1'b0, 0);
    end
    chk("d3_count", 32'(out_count), 32'd16);
    chk("d3_len",   32'(out_len), 32'd16);
    chk("d3_equal", 32'(out_equal), 32'd1);
    chk("d3_trunc", 32'(out_trunc), 32'd1);
    release_result(0, 1'b1, 1'b1, 1'b0, 1'b1);
    send_beat(1'b1, 1'b0, 1'b1, 0);
    chk("d3_next_len", 32'(out_len), 32'd1);

    // Backpressure for five cycles, with a beat waiting across the bubble.
    release_result(5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beat(1'b0, 1'b0, 1'b0, 0);
    send_beat(1'b1, 1'b1, 1'b1, 0);
    chk("d4_len", 32'(out_len), 32'd2);
    release_result(5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-beat frames.
    send_beat(1'b0, 1'b0, 1'b1, 0);
    chk("d5a_count", 32'(out_count), 32'd1);
    chk("d5a_equal", 32'(out_equal), 32'd1);
    release_result(1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(1'b0, 1'b1, 1'b1, 1);
    chk("d5b_count", 32'(out_count), 32'd0);
    chk("d5b_equal", 32'(out_equal), 32'd0);
    release_result(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b1, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fa.delete();
    fb.delete();
    chk("d6_valid", 32'(out_valid), 32'd0);
    chk("d6_ready", 32'(in_ready), 32'd1);
    chk("d6_len",   32'(out_len), 32'd0);
    send_beat(1'b1, 1'b0, 1'b0, 0);
    send_beat(1'b1, 1'b1, 1'b1, 2);
    chk("d6_next_len",   32'(out_len), 32'd2);
    chk("d6_next_count", 32'(out_count), 32'd1);
    release_result(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with idles, truncation and random stall lengths.
    ra = 1'($urandom);
    rb = 1'($urandom);
    rl = ($urandom_range(0, 7) == 0);
    for (int n = 0; n < 400; n++) begin
      send_beat(ra, rb, rl, $urandom_range(0, 2));
      ra = 1'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ~ra : ra;
      rl = ($urandom_range(0, 7) == 0);
      if (m_hold) begin
        pre = 1'($urandom);
        release_result($urandom_range(0, 3), pre, ra, rb, rl);
      end
    end
    if (m_hold) release_result(0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
